// File: rtl/lap_stash.sv
// Lap-sample stash: circular store of BCD times with next/prev browsing.
// Optional LAP_STASH_DELTA_EN adds delta_bcd (viewed entry minus previous).
module lap_stash #(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   time_bcd,
  input  logic                  sample,
  input  logic                  next,
  input  logic                  prev,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   view_bcd,
  output logic [PTR_W-1:0]      view_idx,
  output logic [PTR_W:0]        count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  view_valid
`ifdef LAP_STASH_DELTA_EN
  ,
  output logic [4*DIGITS-1:0]   delta_bcd
`endif
);

  localparam int W = 4 * DIGITS;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t DEP = cnt_t'(DEPTH);

  // Pointer math wraps at DEPTH, which need not be a power of two.
  function automatic ptr_t wadd(cnt_t a, cnt_t b);
    logic [PTR_W+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, DEP}) s = s - {1'b0, DEP};
    return ptr_t'(s);
  endfunction

  function automatic ptr_t wsub(cnt_t a, cnt_t b);
    logic [PTR_W+1:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + {1'b0, DEP} - {1'b0, b};
    return ptr_t'(s);
  endfunction

  logic [W-1:0] mem_q [DEPTH];
  ptr_t         wr_q, wr_d;
  cnt_t         cnt_q, cnt_d;
  ptr_t         vidx_q, vidx_d;
  logic         ovf_q, ovf_d;
  logic         we;
  logic [W-1:0] view_q;
  logic         vvalid_q;
  ptr_t         oldest;
  ptr_t         cur_slot;
  ptr_t         last;

  assign oldest   = wsub({1'b0, wr_q}, cnt_q);
  assign cur_slot = wadd({1'b0, oldest}, {1'b0, vidx_q});
  assign last     = ptr_t'(cnt_q - 1'b1);

  always_comb begin
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    vidx_d = vidx_q;
    ovf_d  = ovf_q;
    we     = 1'b0;
    if (clear) begin
      wr_d   = '0;
      cnt_d  = '0;
      vidx_d = '0;
      ovf_d  = 1'b0;
    end else if (sample) begin
      we   = 1'b1;
      wr_d = wadd({1'b0, wr_q}, cnt_t'(1));
      if (cnt_q == DEP) begin
        ovf_d  = 1'b1;
        vidx_d = ptr_t'(DEP - 1'b1);
      end else begin
        cnt_d  = cnt_q + 1'b1;
        vidx_d = ptr_t'(cnt_q);
      end
    end else if ((next ^ prev) && (cnt_q != '0)) begin
      if (next) vidx_d = (vidx_q == last) ? '0 : vidx_q + 1'b1;
      else      vidx_d = (vidx_q == '0) ? last : vidx_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      cnt_q    <= '0;
      vidx_q   <= '0;
      ovf_q    <= 1'b0;
      view_q   <= '0;
      vvalid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      vidx_q   <= vidx_d;
      ovf_q    <= ovf_d;
      if (we) mem_q[wr_q] <= time_bcd;
      view_q   <= (cnt_q == '0) ? '0 : mem_q[cur_slot];
      vvalid_q <= (cnt_q != '0);
    end
  end

  assign view_bcd   = view_q;
  assign view_valid = vvalid_q;
  assign view_idx   = vidx_q;
  assign count      = cnt_q;
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == DEP);
  assign overflow   = ovf_q;

`ifdef LAP_STASH_DELTA_EN
  function automatic logic [W-1:0] bcd_sub(logic [W-1:0] a,
                                           logic [W-1:0] b);
    logic [W-1:0] r;
    logic [4:0]   d;
    logic         br;
    r  = '0;
    br = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'b0, br};
      if (d[4]) begin
        d  = d + 5'd10;
        br = 1'b1;
      end else begin
        br = 1'b0;
      end
      r[4*i+:4] = d[3:0];
    end
    return r;
  endfunction

  ptr_t         prv_slot;
  logic [W-1:0] delta_q;

  assign prv_slot = wadd({1'b0, oldest}, cnt_t'(vidx_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_q <= '0;
    end else if (cnt_q == '0) begin
      delta_q <= '0;
    end else if (vidx_q == '0) begin
      delta_q <= mem_q[cur_slot];
    end else begin
      delta_q <= bcd_sub(mem_q[cur_slot], mem_q[prv_slot]);
    end
  end

  assign delta_bcd = delta_q;
`endif

endmodule

// File: tb/tb_lap_stash.sv
// Randomised bench for lap_stash against a queue-based lap model.
// Delta output is checked when LAP_STASH_DELTA_EN is defined.
module tb_lap_stash;

  localparam int DIGITS = 4;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int W      = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     time_bcd;
  logic             sample, next, prev, clear;
  logic [W-1:0]     view_bcd;
  logic [PTR_W-1:0] view_idx;
  logic [PTR_W:0]   count;
  logic             empty, full, overflow, view_valid;
`ifdef LAP_STASH_DELTA_EN
  logic [W-1:0]     delta_bcd;
`endif

  lap_stash #(.DIGITS(DIGITS), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_bcd   (time_bcd),
    .sample     (sample),
    .next       (next),
    .prev       (prev),
    .clear      (clear),
    .view_bcd   (view_bcd),
    .view_idx   (view_idx),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .view_valid (view_valid)
`ifdef LAP_STASH_DELTA_EN
    ,
    .delta_bcd  (delta_bcd)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: laps oldest-first, viewed position, sticky overflow flag.
  logic [W-1:0] laps[$];
  int           vi;
  bit           ovf;

  function automatic int bcd2int(logic [W-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i+:4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = 4'($urandom_range(9));
    return r;
  endfunction

  function automatic logic [W-1:0] m_view();
    return (laps.size() == 0) ? '0 : laps[vi];
  endfunction

  function automatic logic [W-1:0] m_delta();
    int m = 1;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    if (laps.size() == 0) return '0;
    if (vi == 0) return laps[0];
    return int2bcd((bcd2int(laps[vi]) - bcd2int(laps[vi-1]) + m) % m);
  endfunction

  function automatic void m_reset();
    laps.delete();
    vi  = 0;
    ovf = 0;
  endfunction

  task automatic cyc(input logic s, input logic n, input logic p,
                     input logic c, input logic [W-1:0] t);
    logic [W-1:0] pv, pd;
    logic         pvalid;
    int           sz;
    time_bcd = t;
    sample   = s;
    next     = n;
    prev     = p;
    clear    = c;
    pv       = m_view();
    pd       = m_delta();
    pvalid   = (laps.size() != 0);
    @(posedge clk);
    if (c) begin
      m_reset();
    end else if (s) begin
      if (laps.size() == DEPTH) begin
        void'(laps.pop_front());
        ovf = 1;
      end
      laps.push_back(t);
      vi = laps.size() - 1;
    end else if (n != p && laps.size() != 0) begin
      sz = laps.size();
      vi = n ? (vi + 1) % sz : (vi + sz - 1) % sz;
    end
    @(negedge clk);
    sample = 0; next = 0; prev = 0; clear = 0;
    chk("count", 32'(count), 32'(laps.size()));
    chk("empty", 32'(empty), 32'(laps.size() == 0));
    chk("full", 32'(full), 32'(laps.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("view_idx", 32'(view_idx), 32'(vi));
    chk("view_bcd", 32'(view_bcd), 32'(pv));
    chk("view_valid", 32'(view_valid), 32'(pvalid));
`ifdef LAP_STASH_DELTA_EN
    chk("delta_bcd", 32'(delta_bcd), 32'(pd));
`else
    pd = '0;
`endif
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, '0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_idx"}, 32'(view_idx), 0);
    chk({tag, "_view"}, 32'(view_bcd), 0);
    chk({tag, "_valid"}, 32'(view_valid), 0);
  endtask

  initial begin
    logic [W-1:0] t;
    rst_n = 0; time_bcd = '0;
    sample = 0; next = 0; prev = 0; clear = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_reset_outs("rst");

    cyc(1, 0, 0, 0, 16'h0012);
    cyc(1, 0, 0, 0, 16'h0034);
    cyc(1, 0, 0, 0, 16'h0056);
    chk("p2_idx", 32'(view_idx), 2);
    idle();
    chk("p2_view", 32'(view_bcd), 32'h0056);
    cyc(0, 1, 0, 0, '0);
    idle();
    chk("p2_next", 32'(view_bcd), 32'h0012);
    cyc(0, 0, 1, 0, '0);
    idle();
    chk("p2_prev", 32'(view_bcd), 32'h0056);

    cyc(0, 0, 0, 1, '0);
    for (int i = 1; i <= 9; i++) cyc(1, 0, 0, 0, int2bcd(i));
    chk("p3_full", 32'(full), 1);
    chk("p3_ovf", 32'(overflow), 1);
    cyc(0, 1, 0, 0, '0);
    idle();
    chk("p3_old", 32'(view_bcd), 32'h0002);
    cyc(0, 0, 1, 0, '0);
    idle();
    chk("p3_new", 32'(view_bcd), 32'h0009);

    cyc(0, 0, 0, 1, '0);
    cyc(1, 0, 0, 0, 16'h0100);
    cyc(1, 1, 0, 0, 16'h0200);
    chk("p4_sn_idx", 32'(view_idx), 1);
    cyc(0, 0, 1, 0, '0);
    cyc(0, 1, 1, 0, '0);
    chk("p4_np_idx", 32'(view_idx), 0);
    cyc(1, 0, 0, 1, 16'h0300);
    idle();
    chk("p4_clr_valid", 32'(view_valid), 0);

    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, rand_bcd());
    #2 rst_n = 0;
    #1 chk_reset_outs("arst");
    @(negedge clk);
    rst_n = 1;
    m_reset();
    cyc(1, 0, 0, 0, 16'h0777);
    idle();
    chk("p5_view", 32'(view_bcd), 32'h0777);

`ifdef LAP_STASH_DELTA_EN
    cyc(0, 0, 0, 1, '0);
    cyc(1, 0, 0, 0, 16'h0105);
    cyc(1, 0, 0, 0, 16'h0230);
    idle();
    chk("p6_d1", 32'(delta_bcd), 32'h0125);
    cyc(0, 1, 0, 0, '0);
    idle();
    chk("p6_d0", 32'(delta_bcd), 32'h0105);
    cyc(1, 0, 0, 0, 16'h9990);
    cyc(1, 0, 0, 0, 16'h0010);
    idle();
    chk("p6_wrap", 32'(delta_bcd), 32'h0020);
`endif

    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(99));
      t = ($urandom_range(3) == 0) ? time_bcd : rand_bcd();
      cyc(r < 35, $urandom_range(3) == 0, $urandom_range(3) == 0,
          r == 99 || (r > 95 && k % 7 == 0), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_stash.md
Name: lap_stash

Overview:
Parametrised lap-sample store for the stopwatch datapath: captures the live BCD time on each sample pulse into a circular buffer of DEPTH entries and lets the user browse the stored laps with next/prev. It sits between the time counter and the display mux. It replaces the fixed single-slot stash with configurable digit count and depth, oldest-overwrite, and an overflow indication.

Parameters:
DIGITS, 4, number of BCD digits per sample (sample width 4*DIGITS)
DEPTH, 8, stored entries; legal 2..16, not required to be a power of two
PTR_W, 3, pointer width; must satisfy 2**PTR_W >= DEPTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
time_bcd  in  4*DIGITS  live stopwatch time, BCD, digit 0 in LSBs
sample  in  1  single-cycle pulse (debounced upstream); capture time_bcd
next  in  1  single-cycle pulse; browse towards newer entry
prev  in  1  single-cycle pulse; browse towards older entry
clear  in  1  single-cycle pulse; empty the stash
view_bcd  out  4*DIGITS  entry currently viewed (registered)
view_idx  out  PTR_W  viewed position, 0 = oldest stored
count  out  PTR_W+1  entries stored, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky; an entry was overwritten since last clear/reset
view_valid  out  1  view_bcd holds a stored entry (count != 0)

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, count=0, view_idx=0, overflow=0, view_bcd=0, view_valid=0, empty=1, full=0. Storage contents are don't-care and never visible while empty.
- Oldest entry is at slot (wr_ptr - count) mod DEPTH; the viewed slot is (oldest + view_idx) mod DEPTH. All pointer arithmetic wraps explicitly at DEPTH.
- Event priority per cycle: clear > sample > next/prev. A lower-priority pulse coinciding with a higher one is dropped, not deferred.
- clear: count=0, view_idx=0, wr_ptr=0, overflow=0.
- sample, not full: write time_bcd at wr_ptr; wr_ptr+1 mod DEPTH; count+1; view_idx = new count-1 (jump to newest).
- sample when full: overwrite oldest slot (== wr_ptr); wr_ptr+1 mod DEPTH; count stays DEPTH; overflow=1; view_idx=DEPTH-1.
- next alone: view_idx+1, wraps from count-1 to 0.
- prev alone: view_idx-1, wraps from 0 to count-1.
- next and prev in the same cycle: no change.
- Browsing when empty: ignored.
- count, empty, full, overflow and view_idx update on the edge that samples the event.
- view_bcd and view_valid are registered from the post-update state, so they change one clock after that edge (1-cycle latency). view_bcd is forced to 0 whenever the stash is empty.
- sample with time_bcd unchanged is still stored; no deduplication.

Optional Feature:
Macro LAP_STASH_DELTA_EN.
- Defined: adds output delta_bcd [4*DIGITS-1:0], registered with the same latency as view_bcd.
  - view_idx 0: delta_bcd = the viewed entry itself.
  - Otherwise: delta_bcd = viewed entry minus the entry at view_idx-1, computed as digit-wise decimal subtraction with borrow. A negative result wraps modulo 10**DIGITS.
  - delta_bcd is 0 when empty.
- Undefined: no port, no subtractor logic.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> count=0, empty=1, full=0, overflow=0, view_valid=0, view_bcd=0x0000.
2. Sample 0x0012, 0x0034, 0x0056 -> count=3, view_idx=2, view_bcd=0x0056 one cycle later; pulse next -> view_idx=0, view_bcd=0x0012; pulse prev -> view_idx=2, view_bcd=0x0056.
3. DEPTH=8: sample 0x0001..0x0009 -> count=8, full=1, overflow=1; browse to view_idx=0 -> view_bcd=0x0002; view_idx=7 -> 0x0009.
4. Pulse sample and next together -> entry stored, view_idx=newest. Pulse clear and sample together -> count=0, empty=1, overflow=0, view_valid=0 next cycle. Pulse next and prev together -> view_idx unchanged.
5. Drop rst_n asynchronously mid-stream with count=5 -> all outputs return to reset values immediately, without waiting for a clock edge. A subsequent sample of 0x0777 -> count=1, view_bcd=0x0777.
6. With LAP_STASH_DELTA_EN: sample 0x0105, then 0x0230 -> at view_idx=1, delta_bcd=0x0125; at view_idx=0, delta_bcd=0x0105. Sample 0x9990, then 0x0010 -> delta at the newest entry is 0x0020 (modulo wrap).
